// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing the write channel of one axi_master among P_NUM_REQ clients.
// Build macro AXI_WR_ARB_LEN_CHECK_EN: generate M_W_LAST_O from LEN and flag LAST_I mismatches on ERR_O.
module axi_wr_arbiter #(
  parameter int P_NUM_REQ      = 4,
  parameter int P_A_BITWIDTH   = 32,
  parameter int P_D_BITWIDTH   = 32,
  parameter int P_IDX_BITWIDTH = $clog2(P_NUM_REQ)
) (
  input  logic                                CLK_I,
  input  logic                                RST_I,
  input  logic [P_NUM_REQ-1:0]                REQ_I,
  input  logic [P_NUM_REQ*P_A_BITWIDTH-1:0]   ADDR_I,
  input  logic [P_NUM_REQ*8-1:0]              LEN_I,
  input  logic [P_NUM_REQ*3-1:0]              SIZE_I,
  input  logic [P_NUM_REQ*P_D_BITWIDTH-1:0]   DATA_I,
  input  logic [P_NUM_REQ-1:0]                VALID_I,
  input  logic [P_NUM_REQ-1:0]                LAST_I,
  output logic [P_NUM_REQ-1:0]                READY_O,
  output logic [P_NUM_REQ-1:0]                GNT_O,
  output logic [P_NUM_REQ-1:0]                DONE_O,
  output logic [1:0]                          RESP_O,
  output logic                                ERR_O,
  output logic                                M_W_REQ_O,
  output logic [P_A_BITWIDTH-1:0]             M_W_ADDR_O,
  output logic [7:0]                          M_W_LEN_O,
  output logic [2:0]                          M_W_SIZE_O,
  output logic [P_D_BITWIDTH-1:0]             M_W_DATA_O,
  output logic                                M_W_VALID_O,
  output logic                                M_W_LAST_O,
  input  logic                                M_W_READY_I,
  input  logic                                M_W_DONE_I,
  input  logic [1:0]                          M_W_RESP_I
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t                    r_state, w_state_nxt;
  logic [P_IDX_BITWIDTH-1:0] r_idx, r_ptr, w_sel, w_cand, w_ptr_nxt;
  logic [P_NUM_REQ-1:0]      r_gnt, r_done, w_sel_oh;
  logic                      w_hit, w_busy, w_beat, w_last;
  logic [P_A_BITWIDTH-1:0]   r_addr;
  logic [7:0]                r_len;
  logic [2:0]                r_size;
  logic [1:0]                r_resp;

  // Scan upward from r_ptr with wrap; the first requester found wins.
  always_comb begin
    w_hit    = 1'b0;
    w_sel    = '0;
    w_cand   = '0;
    w_sel_oh = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      w_cand = P_IDX_BITWIDTH'((int'(r_ptr) + i) % P_NUM_REQ);
      if (!w_hit && REQ_I[w_cand]) begin
        w_hit            = 1'b1;
        w_sel            = w_cand;
        w_sel_oh[w_cand] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (r_idx == P_IDX_BITWIDTH'(P_NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge CLK_I) begin
    if (RST_I) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    M_W_REQ_O   = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_hit) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        M_W_REQ_O   = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (M_W_DONE_I) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Zero-latency data mux for the owner; everyone else sees READY_O low.
  always_comb begin
    READY_O = '0;
    if (w_busy) READY_O[r_idx] = M_W_READY_I;
  end

  assign M_W_VALID_O = w_busy & VALID_I[r_idx];
  assign M_W_DATA_O  = w_busy ? DATA_I[r_idx*P_D_BITWIDTH +: P_D_BITWIDTH] : '0;
  assign w_beat      = M_W_VALID_O & M_W_READY_I;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_idx  <= '0;
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_done <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_resp <= '0;
    end else begin
      r_done <= '0;
      // GNT_O stays up through the DONE cycle and is only replaced by the next arbitration.
      if (r_state == S_IDLE) begin
        r_gnt <= w_sel_oh;
        if (w_hit) begin
          r_idx  <= w_sel;
          r_addr <= ADDR_I[w_sel*P_A_BITWIDTH +: P_A_BITWIDTH];
          r_len  <= LEN_I[w_sel*8 +: 8];
          r_size <= SIZE_I[w_sel*3 +: 3];
        end
      end
      if (w_busy && M_W_DONE_I) begin
        r_done <= r_gnt;
        r_resp <= M_W_RESP_I;
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
  logic [7:0] r_cnt;
  logic       r_err;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (w_beat)        r_cnt <= r_cnt + 1'b1;
      if (w_beat && (LAST_I[r_idx] != w_last)) r_err <= 1'b1;
    end
  end

  assign w_last = w_busy && (r_cnt == r_len);
  assign ERR_O  = r_err;
`else
  assign w_last = w_busy & LAST_I[r_idx];
  assign ERR_O  = 1'b0;
`endif

  assign M_W_LAST_O = w_last;
  assign M_W_ADDR_O = r_addr;
  assign M_W_LEN_O  = r_len;
  assign M_W_SIZE_O = r_size;
  assign GNT_O      = r_gnt;
  assign DONE_O     = r_done;
  assign RESP_O     = r_resp;

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin arbiter that shares the write channel of one `axi_master` between `P_NUM_REQ` requesters. It grants one requester at a time and forwards that requester's command once. It then muxes the requester's data stream onto the master until the master reports write completion, and returns the response to the owner. It sits between the DMA/accelerator write clients and the single `axi_master` instance on the memory bus.

## Interface
Parameters:
- `P_NUM_REQ`, 4: number of requesters, 2..16.
- `P_A_BITWIDTH`, 32: address width.
- `P_D_BITWIDTH`, 32: data width.
- `P_IDX_BITWIDTH`, `$clog2(P_NUM_REQ)`: grant index width.

Ports. The block has one clock; reset is synchronous and active-high.
- `CLK_I`, in, 1: clock.
- `RST_I`, in, 1: synchronous active-high reset.
- `REQ_I`, in, N: per-requester write request. Level; held until that requester's `GNT_O` bit rises.
- `ADDR_I`, in, N*A: packed burst addresses. Requester k uses slice [k*A +: A].
- `LEN_I`, in, N*8: packed burst lengths (beats-1).
- `SIZE_I`, in, N*3: packed AXI beat sizes.
- `DATA_I`, in, N*D: packed write data.
- `VALID_I`, in, N: per-requester data valid.
- `LAST_I`, in, N: per-requester last-beat flag.
- `READY_O`, out, N: per-requester data ready. Only the granted bit can be 1.
- `GNT_O`, out, N: one-hot ownership. High from the ISSUE cycle until the DONE cycle, inclusive.
- `DONE_O`, out, N: one-cycle completion pulse to the owner.
- `RESP_O`, out, 2: BRESP of the last completed burst. Valid while `DONE_O` is nonzero.
- `ERR_O`, out, 1: sticky LAST/length mismatch flag. See Configuration.
- `M_W_REQ_O`, `M_W_ADDR_O`, `M_W_LEN_O`, `M_W_SIZE_O`, out: command to the master.
- `M_W_DATA_O`, `M_W_VALID_O`, `M_W_LAST_O`, out: data to the master.
- `M_W_READY_I`, `M_W_DONE_I`, `M_W_RESP_I`, in: handshake and completion from the master.

## Operation
- State machine has three states: IDLE, ISSUE, BUSY.
- IDLE: if `REQ_I` is nonzero, choose the first set bit scanning upward from `rr_ptr` with wrap-around. Register the grant index and that requester's ADDR/LEN/SIZE, then go to ISSUE. If `REQ_I` is zero, stay in IDLE.
- ISSUE: exactly one cycle. `M_W_REQ_O`=1 with the registered command. The master accepts the command unconditionally. Go to BUSY.
- BUSY:
  - Data path is combinational for the granted index g: `M_W_DATA_O`=DATA_I[g], `M_W_VALID_O`=VALID_I[g], `READY_O[g]`=`M_W_READY_I`.
  - A beat transfers when VALID and READY are both 1.
  - On `M_W_DONE_I`=1: `DONE_O[g]` pulses next cycle and `RESP_O` is registered from `M_W_RESP_I`. `rr_ptr` becomes (g+1) mod N. State returns to IDLE.
- Fairness: a requester that re-asserts `REQ_I` in the same cycle it completes has lowest priority in the next arbitration.
- Non-owners always see `READY_O`=0. `REQ_I` changes from non-owners during BUSY are ignored until IDLE.
- Reset values: all outputs 0, `ERR_O`=0, `rr_ptr`=0, state IDLE.
- Reset mid-burst abandons the burst with no `DONE_O`. The master shares `RST_I` and must be reset with the arbiter.

## Timing
- Arbitration latency: `REQ_I` sampled in IDLE at cycle t gives `GNT_O` and `M_W_REQ_O` at t+1.
- Completion: `M_W_DONE_I` at cycle d gives `DONE_O`/`RESP_O` at d+1. The block is back in IDLE at d+1, so the next `M_W_REQ_O` is at d+2 at the earliest.
- Data path adds zero cycles in either direction.
- Back-to-back bursts have a minimum 2-cycle gap on `M_W_REQ_O`.

## Configuration
- `AXI_WR_ARB_LEN_CHECK_EN` defined:
  - An 8-bit beat counter clears in ISSUE and increments per transferred beat.
  - `M_W_LAST_O` is generated as (count == LEN) and ignores `LAST_I`.
  - `ERR_O` sets, and stays set until reset, if `LAST_I[g]` differs from the generated LAST on any transferred beat.
- `AXI_WR_ARB_LEN_CHECK_EN` undefined:
  - `M_W_LAST_O` = `LAST_I[g]` passthrough.
  - No counter is instantiated; `ERR_O` is tied 0.

## Test plan
- Single request: N=4, REQ_I=4'b0010, ADDR 0x1000, LEN 3. Required: GNT_O=0010 and M_W_REQ_O the next cycle; 4 beats forwarded; M_W_DONE_I gives DONE_O=0010 and RESP_O=M_W_RESP_I one cycle later.
- Round-robin: REQ_I=4'b1111 held. Required: grants in order 0,1,2,3,0, with each grant following the previous DONE by exactly one cycle.
- Backpressure: M_W_READY_I toggles 1,0,0,1. Required: READY_O of the owner mirrors it; non-owner READY_O stays 0; no beat duplicated or dropped.
- Reset mid-burst: RST_I during BUSY after 2 of 4 beats. Required: next cycle all outputs 0 and state IDLE; the following request is granted to index 0 first.
- LEN check, macro defined: LEN 3 with LAST_I asserted on beat 1. Required: M_W_LAST_O only on beat 3, ERR_O=1 and sticky. With the macro undefined: M_W_LAST_O on beat 1, ERR_O=0.
